vga_scan_ctrl: RTL and testbench

//  Raster timing generator and pixel output stage for the DE2-115 VGA port.
//  - Produces the x_cnt/y_cnt scan coordinates consumed by the UNO glyph/card renderers.
//  - Registers the merged renderer RGB onto the ADV7123 pins with aligned sync/blank.
//  - Sits between the pixel-clock domain top level and the combinational sprite layer.

---
 rtl/uno_vga_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 44 ++++
 rtl/vga_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_vga_scan_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uno_vga_pkg.sv
// ---------------------------------------------------------------------------
// uno_vga_pkg
//   Shared types and default 640x480@60 timing for the UNO VGA scan path.
//   coord_t : 10-bit raster coordinate (totals up to 1024)
//   rgb_t   : packed 8/8/8 colour triple as driven onto the ADV7123
//   in_window() : half-open range test used for the sync windows
// ---------------------------------------------------------------------------
package uno_vga_pkg;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam bit SYNC_POL_DEF = 1'b0;

  // True when lo <= c < hi.
  function automatic logic in_window(coord_t c, coord_t lo, coord_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
//   Generic wrap counter for one raster axis with a window decode.
//   Ports:
//     i_clk    : clock
//     i_rst    : synchronous active-high reset, clears the count
//     i_en     : advance enable (pixel tick, optionally ANDed with a carry)
//     i_wrap   : when high together with i_en, return to 0 instead of +1
//     o_cnt    : current position
//     o_in_win : 1 while WIN_LO <= o_cnt < WIN_HI
//   The wrap condition comes from outside so that the parent can chain the
//   vertical axis on the horizontal end-of-line without a dangling output.
// ---------------------------------------------------------------------------
module vga_axis_counter
  import uno_vga_pkg::*;
#(
  parameter int WIN_LO = 656,
  parameter int WIN_HI = 752
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_wrap,
  output logic [9:0] o_cnt,
  output logic       o_in_win
);

  localparam coord_t LO = coord_t'(WIN_LO);
  localparam coord_t HI = coord_t'(WIN_HI);

  coord_t r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= i_wrap ? '0 : r_cnt + 10'd1;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_in_win = in_window(r_cnt, LO, HI);

endmodule

// File: rtl/vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// vga_scan_ctrl
//   Raster timing generator and registered pixel output stage for the
//   DE2-115 VGA DAC (ADV7123).
//   Ports:
//     i_clk, i_rst        : 50 MHz clock, synchronous active-high reset
//     i_pix_en            : 25 MHz pixel tick; every register advances only on it
//     i_r_in/g_in/b_in    : renderer colour for the current o_x_cnt/o_y_cnt
//     o_x_cnt, o_y_cnt    : scan position
//     o_active            : position is inside the visible area
//     o_line_start        : one-clk pulse on the tick where x == 0
//     o_frame_start       : one-clk pulse on the tick where x == 0 and y == 0
//     o_vga_r/g/b         : registered colour, forced black outside the visible area
//     o_vga_hs, o_vga_vs  : registered syncs, aligned with the colour
//     o_vga_blank_n       : registered, low outside the visible area
//     o_vga_sync_n        : tied low (no sync-on-green)
// ---------------------------------------------------------------------------
module vga_scan_ctrl
  import uno_vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_POL_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_en,
  input  logic [7:0] i_r_in,
  input  logic [7:0] i_g_in,
  input  logic [7:0] i_b_in,
  output logic [9:0] o_x_cnt,
  output logic [9:0] o_y_cnt,
  output logic       o_active,
  output logic       o_line_start,
  output logic       o_frame_start,
  output logic [7:0] o_vga_r,
  output logic [7:0] o_vga_g,
  output logic [7:0] o_vga_b,
  output logic       o_vga_hs,
  output logic       o_vga_vs,
  output logic       o_vga_blank_n,
  output logic       o_vga_sync_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS   = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS   = coord_t'(V_ACTIVE);

  coord_t w_x;
  coord_t w_y;
  logic   w_xLast;
  logic   w_yLast;
  logic   w_hWin;
  logic   w_vWin;
  logic   w_active;
  rgb_t   w_pixIn;

  rgb_t   r_pix;
  logic   r_hs;
  logic   r_vs;
  logic   r_blankN;

  assign w_xLast = (w_x == H_LAST);
  assign w_yLast = (w_y == V_LAST);

  vga_axis_counter #(
    .WIN_LO (H_ACTIVE + H_FP),
    .WIN_HI (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_pix_en),
    .i_wrap   (w_xLast),
    .o_cnt    (w_x),
    .o_in_win (w_hWin)
  );

  // The vertical axis only moves on the last pixel of a line, so its
  // wrap naturally coincides with the horizontal wrap at the frame end.
  vga_axis_counter #(
    .WIN_LO (V_ACTIVE + V_FP),
    .WIN_HI (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_pix_en & w_xLast),
    .i_wrap   (w_yLast),
    .o_cnt    (w_y),
    .o_in_win (w_vWin)
  );

  assign w_active = (w_x < H_VIS) && (w_y < V_VIS);
  assign w_pixIn  = '{r: i_r_in, g: i_g_in, b: i_b_in};

  // Output stage: colour, syncs and blank share one register stage so
  // they reach the DAC pins on the same pixel. Colour outside the visible
  // area is replaced by black before it is captured.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix    <= '0;
      r_hs     <= ~SYNC_POL;
      r_vs     <= ~SYNC_POL;
      r_blankN <= 1'b0;
    end else if (i_pix_en) begin
      r_pix    <= w_active ? w_pixIn : '0;
      r_hs     <= w_hWin ? SYNC_POL : ~SYNC_POL;
      r_vs     <= w_vWin ? SYNC_POL : ~SYNC_POL;
      r_blankN <= w_active;
    end
  end

  assign o_x_cnt       = w_x;
  assign o_y_cnt       = w_y;
  assign o_active      = w_active;
  assign o_line_start  = i_pix_en && (w_x == '0);
  assign o_frame_start = i_pix_en && (w_x == '0) && (w_y == '0);

  assign o_vga_r       = r_pix.r;
  assign o_vga_g       = r_pix.g;
  assign o_vga_b       = r_pix.b;
  assign o_vga_hs      = r_hs;
  assign o_vga_vs      = r_vs;
  assign o_vga_blank_n = r_blankN;
  assign o_vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_ctrl
//   Drives two instances from the same stimulus: one with the default
//   640x480 timing and one with a tiny raster (25 x 19) so that whole
//   frames fit in a short run. The reference derives every expected value
//   from the number of enabled ticks since the last reset.
// ---------------------------------------------------------------------------
module tb_vga_scan_ctrl;

  // Small raster: 16+2+4+3 = 25 pixels, 12+2+2+3 = 19 lines.
  localparam int SH_A = 16, SH_FP = 2, SH_S = 4, SH_BP = 3;
  localparam int SV_A = 12, SV_FP = 2, SV_S = 2, SV_BP = 3;
  localparam int S_FRAME = (SH_A + SH_FP + SH_S + SH_BP) * (SV_A + SV_FP + SV_S + SV_BP);

  typedef struct {
    int x, y, r, g, b;
    bit act, ls, fs, hs, vs, bl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic pixEn;
  logic [7:0] rIn, gIn, bIn;

  logic [9:0] fX, fY, sX, sY;
  logic fAct, fLs, fFs, fHs, fVs, fBl, fSn;
  logic sAct, sLs, sFs, sHs, sVs, sBl, sSn;
  logic [7:0] fR, fG, fB, sR, sG, sB;

  int checks = 0;
  int failures = 0;
  int ticks = 0;
  logic [23:0] lastIn = '0;
  int fsCount, vsLowCount, hsLowFull, lsFull;

  always #5 clk = ~clk;

  vga_scan_ctrl dutFull (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pixEn),
    .i_r_in(rIn), .i_g_in(gIn), .i_b_in(bIn),
    .o_x_cnt(fX), .o_y_cnt(fY), .o_active(fAct),
    .o_line_start(fLs), .o_frame_start(fFs),
    .o_vga_r(fR), .o_vga_g(fG), .o_vga_b(fB),
    .o_vga_hs(fHs), .o_vga_vs(fVs),
    .o_vga_blank_n(fBl), .o_vga_sync_n(fSn)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP),
    .SYNC_POL(1'b0)
  ) dutSmall (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pixEn),
    .i_r_in(rIn), .i_g_in(gIn), .i_b_in(bIn),
    .o_x_cnt(sX), .o_y_cnt(sY), .o_active(sAct),
    .o_line_start(sLs), .o_frame_start(sFs),
    .o_vga_r(sR), .o_vga_g(sG), .o_vga_b(sB),
    .o_vga_hs(sHs), .o_vga_vs(sVs),
    .o_vga_blank_n(sBl), .o_vga_sync_n(sSn)
  );

  // Expected view of one instance after k enabled ticks since reset.
  function automatic exp_t calcExp(int k, bit en, int hA, int hFp, int hS, int hBp,
                                   int vA, int vFp, int vS, int vBp, logic [23:0] pix);
    exp_t e;
    int hT, vT, px, py;
    bit pAct;
    hT = hA + hFp + hS + hBp;
    vT = vA + vFp + vS + vBp;
    e.x   = k % hT;
    e.y   = (k / hT) % vT;
    e.act = (e.x < hA) && (e.y < vA);
    e.ls  = en && (e.x == 0);
    e.fs  = e.ls && (e.y == 0);
    if (k == 0) begin
      e.r = 0; e.g = 0; e.b = 0;
      e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0;
    end else begin
      px   = (k - 1) % hT;
      py   = ((k - 1) / hT) % vT;
      pAct = (px < hA) && (py < vA);
      e.r  = pAct ? int'(pix[23:16]) : 0;
      e.g  = pAct ? int'(pix[15:8]) : 0;
      e.b  = pAct ? int'(pix[7:0]) : 0;
      e.hs = !((px >= hA + hFp) && (px < hA + hFp + hS));
      e.vs = !((py >= vA + vFp) && (py < vA + vFp + vS));
      e.bl = pAct;
    end
    return e;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, expv, ticks);
    end
  endtask

  task automatic compareAll();
    exp_t ef, es;
    ef = calcExp(ticks, pixEn, 640, 16, 96, 48, 480, 10, 2, 33, lastIn);
    es = calcExp(ticks, pixEn, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP, lastIn);
    checkOutput("full.x", 32'(fX), ef.x);
    checkOutput("full.y", 32'(fY), ef.y);
    checkOutput("full.active", 32'(fAct), 32'(ef.act));
    checkOutput("full.lineStart", 32'(fLs), 32'(ef.ls));
    checkOutput("full.frameStart", 32'(fFs), 32'(ef.fs));
    checkOutput("full.rgb", {8'h0, fR, fG, fB}, {8'h0, 8'(ef.r), 8'(ef.g), 8'(ef.b)});
    checkOutput("full.hs", 32'(fHs), 32'(ef.hs));
    checkOutput("full.vs", 32'(fVs), 32'(ef.vs));
    checkOutput("full.blankN", 32'(fBl), 32'(ef.bl));
    checkOutput("full.syncN", 32'(fSn), 32'd0);
    checkOutput("small.x", 32'(sX), es.x);
    checkOutput("small.y", 32'(sY), es.y);
    checkOutput("small.active", 32'(sAct), 32'(es.act));
    checkOutput("small.lineStart", 32'(sLs), 32'(es.ls));
    checkOutput("small.frameStart", 32'(sFs), 32'(es.fs));
    checkOutput("small.rgb", {8'h0, sR, sG, sB}, {8'h0, 8'(es.r), 8'(es.g), 8'(es.b)});
    checkOutput("small.hs", 32'(sHs), 32'(es.hs));
    checkOutput("small.vs", 32'(sVs), 32'(es.vs));
    checkOutput("small.blankN", 32'(sBl), 32'(es.bl));
    checkOutput("small.syncN", 32'(sSn), 32'd0);
  endtask

  // One clk: drive inputs just after the edge, check at the falling edge,
  // then advance the reference across the next rising edge.
  task automatic applyStimulus(bit rstV, bit enV);
    rst   = rstV;
    pixEn = enV;
    {rIn, gIn, bIn} = 24'($urandom);
    @(negedge clk);
    compareAll();
    if (sFs) fsCount++;
    if (enV && !sVs) vsLowCount++;
    if (enV && !fHs) hsLowFull++;
    if (fLs) lsFull++;
    @(posedge clk);
    if (rstV) begin
      ticks = 0;
    end else if (enV) begin
      lastIn = {rIn, gIn, bIn};
      ticks++;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pixEn = 1'b1;
    {rIn, gIn, bIn} = 24'hFF0000;
    repeat (3) @(posedge clk);
    #1;
    ticks = 0;

    // Reset held: outputs must sit at their reset values.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);

    // Three small frames plus more than a full-raster line from reset.
    fsCount = 0; vsLowCount = 0; hsLowFull = 0; lsFull = 0;
    repeat (3 * S_FRAME) applyStimulus(1'b0, 1'b1);
    checkOutput("small.frameStartCount", fsCount, 3);
    checkOutput("small.vsLowTicks", vsLowCount, 3 * SV_S * (SH_A + SH_FP + SH_S + SH_BP));
    checkOutput("full.hsLowTicks", hsLowFull, 96);
    checkOutput("full.lineStartCount", lsFull, 2);

    // Enable pattern 1,0,0,1: counters and outputs hold on the zeros.
    repeat (8) begin
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
    end

    // Mid-frame resets, once while ticking and once between ticks.
    repeat (37) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1);

    // Random enables with occasional resets.
    repeat (2500) applyStimulus($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
